cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core_if.sv | 21 ++
 rtl/cpu_core.sv | 126 ++++++++++++
 tb/tb_cpu_core.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_if.sv
// Load/observe bus of cpu_core: instruction-memory write port plus architectural state outputs.
interface cpu_core_if;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic [7:0]  pc;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic        flag_n;
    logic        flag_z;

    modport master (
        output load_en, load_addr, load_data,
        input  pc, read_data1, read_data2, flag_n, flag_z
    );

    modport slave (
        input  load_en, load_addr, load_data,
        output pc, read_data1, read_data2, flag_n, flag_z
    );
endinterface

// File: rtl/cpu_core.sv
// Single-cycle 16-bit CPU: 256x16 instruction memory, 16x16 register file, N/Z flags.
// Optional macro COND_BRANCH_EN adds JZ (op 1000) and JN (op 1001).
module cpu_core (
    input  logic     clk,
    input  logic     reset,
    cpu_core_if.slave bus
);
    typedef enum logic [3:0] {
        OP_LOAD = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_CMP  = 4'h6,
        OP_JMP  = 4'h7,
        OP_JZ   = 4'h8,
        OP_JN   = 4'h9
    } op_e;

    logic [15:0] imem [256];
    logic [15:0] regs [16];
    logic [7:0]  pc_q;
    logic        n_q;
    logic        z_q;

    logic [15:0] instr;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [7:0]  imm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] alu_res;
    logic [15:0] reg_wdata;
    logic [7:0]  pc_next;
    logic        reg_we;
    logic        flag_we;

    assign instr = imem[pc_q];
    assign rd    = instr[11:8];
    assign rs    = instr[7:4];
    assign imm   = instr[7:0];
    assign a     = regs[rd];
    assign b     = regs[rs];

    always_comb begin
        pc_next   = pc_q + 8'd1;
        alu_res   = '0;
        reg_wdata = '0;
        reg_we    = 1'b0;
        flag_we   = 1'b0;
        case (instr[15:12])
            OP_LOAD: begin
                reg_we    = 1'b1;
                reg_wdata = {8'h00, imm};
            end
            OP_ADD: begin
                alu_res   = a + b;
                reg_wdata = alu_res;
                reg_we    = 1'b1;
                flag_we   = 1'b1;
            end
            OP_SUB: begin
                alu_res   = a - b;
                reg_wdata = alu_res;
                reg_we    = 1'b1;
                flag_we   = 1'b1;
            end
            OP_AND: begin
                alu_res   = a & b;
                reg_wdata = alu_res;
                reg_we    = 1'b1;
                flag_we   = 1'b1;
            end
            OP_OR: begin
                alu_res   = a | b;
                reg_wdata = alu_res;
                reg_we    = 1'b1;
                flag_we   = 1'b1;
            end
            OP_XOR: begin
                alu_res   = a ^ b;
                reg_wdata = alu_res;
                reg_we    = 1'b1;
                flag_we   = 1'b1;
            end
            OP_CMP: begin
                alu_res = a - b;
                flag_we = 1'b1;
            end
            OP_JMP: pc_next = imm;
`ifdef COND_BRANCH_EN
            OP_JZ: if (z_q) pc_next = imm;
            OP_JN: if (n_q) pc_next = imm;
`endif
            default: ;
        endcase
    end

    // Memory writes ignore reset so programs can be loaded while the core is held.
    always_ff @(posedge clk) begin
        if (bus.load_en) imem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= '0;
            n_q  <= 1'b0;
            z_q  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) regs[4'(i)] <= '0;
        end else begin
            pc_q <= pc_next;
            if (reg_we) regs[rd] <= reg_wdata;
            if (flag_we) begin
                n_q <= alu_res[15];
                z_q <= (alu_res == '0);
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.read_data1 = a;
    assign bus.read_data2 = b;
    assign bus.flag_n     = n_q;
    assign bus.flag_z     = z_q;
endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: table-driven program traces plus hand-written corner sequences.
module tb_cpu_core;
    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        n;
        logic        z;
    } exp_t;

    typedef struct {
        int   ncyc;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exp_t        exp_q[$];
    string       tag_q[$];
    logic [15:0] prog_q[$];
    vec_t        tr_a[10];
    vec_t        tr_b[9];

    cpu_core_if bus ();

    cpu_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [7:0] p, input logic [15:0] r1,
                                input logic [15:0] r2, input logic n, input logic z);
        exp_t e;
        e.pc  = p;
        e.rd1 = r1;
        e.rd2 = r2;
        e.n   = n;
        e.z   = z;
        return e;
    endfunction

    task automatic check_front();
        exp_t  e;
        exp_t  got;
        string t;
        got = {bus.pc, bus.read_data1, bus.read_data2, bus.flag_n, bus.flag_z};
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got pc=%h rd1=%h rd2=%h n=%b z=%b, want pc=%h rd1=%h rd2=%h n=%b z=%b",
                     t, got.pc, got.rd1, got.rd2, got.n, got.z, e.pc, e.rd1, e.rd2, e.n, e.z);
        end
    endtask

    // Queue the expectation, advance ncyc edges, then compare at the falling edge.
    task automatic expect_after(input string tag, input int ncyc, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        repeat (ncyc) @(posedge clk);
        if (ncyc > 0) @(negedge clk);
        check_front();
    endtask

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        @(posedge clk);
        @(negedge clk);
        bus.load_en   = 1'b0;
    endtask

    task automatic clear_mem();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) write_word(8'(i), 16'h0000);
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog_q.size(); i++) write_word(8'(i), prog_q[i]);
    endtask

    initial begin
        tr_a[0] = '{0, mk(8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0)};
        tr_a[1] = '{1, mk(8'h01, 16'h0000, 16'h0001, 1'b0, 1'b0)};
        tr_a[2] = '{1, mk(8'h02, 16'h0001, 16'h0002, 1'b0, 1'b0)};
        tr_a[3] = '{1, mk(8'h03, 16'h0003, 16'h0002, 1'b0, 1'b0)};
        tr_a[4] = '{1, mk(8'h04, 16'h0001, 16'h0002, 1'b0, 1'b0)};
        tr_a[5] = '{1, mk(8'h05, 16'h0001, 16'h0001, 1'b1, 1'b0)};
        tr_a[6] = '{1, mk(8'h08, 16'h0000, 16'h0001, 1'b1, 1'b0)};
        tr_a[7] = '{1, mk(8'h09, 16'h0001, 16'h0002, 1'b1, 1'b0)};
        tr_a[8] = '{1, mk(8'h0A, 16'h0000, 16'h0004, 1'b1, 1'b0)};
        tr_a[9] = '{1, mk(8'h0B, 16'h0001, 16'h0001, 1'b1, 1'b0)};

        tr_b[0] = '{0, mk(8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0)};
        tr_b[1] = '{1, mk(8'h01, 16'h0000, 16'h0000, 1'b0, 1'b0)};
        tr_b[2] = '{1, mk(8'h02, 16'h000F, 16'h003C, 1'b0, 1'b0)};
        tr_b[3] = '{1, mk(8'h03, 16'h000C, 16'h003C, 1'b0, 1'b0)};
        tr_b[4] = '{1, mk(8'h04, 16'h003C, 16'h003C, 1'b0, 1'b0)};
        tr_b[5] = '{1, mk(8'h05, 16'h0000, 16'h0000, 1'b0, 1'b1)};
        tr_b[6] = '{1, mk(8'h06, 16'h0000, 16'h003C, 1'b0, 1'b1)};
        tr_b[7] = '{1, mk(8'h07, 16'hFFC4, 16'h003C, 1'b1, 1'b0)};
        tr_b[8] = '{1, mk(8'h08, 16'h0000, 16'h0000, 1'b1, 1'b0)};

        reset         = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        @(negedge clk);

        clear_mem();
        expect_after("reset_state", 0, mk(8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0));

        // Reference program with two probe NOPs (op F) at 9/10 exposing R0..R3.
        prog_q = '{16'h0001, 16'h0102, 16'h1010, 16'h2010, 16'h6010, 16'h7008,
                   16'h0000, 16'h0203, 16'h0304, 16'hF010, 16'hF230};
        load_prog();
        reset = 1'b1;
        for (int i = 0; i < 10; i++)
            expect_after($sformatf("trace_a[%0d]", i), tr_a[i].ncyc, tr_a[i].e);

        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        expect_after("pre_reset_pc5", 5, mk(8'h05, 16'h0001, 16'h0001, 1'b1, 1'b0));
        reset = 1'b0;
        expect_after("mid_reset", 1, mk(8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0));
        reset = 1'b1;
        expect_after("restart_imem0", 1, mk(8'h01, 16'h0000, 16'h0001, 1'b0, 1'b0));

        clear_mem();
        prog_q = '{16'h010F, 16'h023C, 16'h3120, 16'h4120, 16'h5120, 16'h2330,
                   16'h2320, 16'hF320};
        load_prog();
        reset = 1'b1;
        for (int i = 0; i < 9; i++)
            expect_after($sformatf("trace_b[%0d]", i), tr_b[i].ncyc, tr_b[i].e);

        // Overwriting the word being executed: the old word runs this cycle.
        clear_mem();
        write_word(8'h01, 16'h7100);
        reset         = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 8'h00;
        bus.load_data = 16'h0105;
        @(posedge clk);
        @(negedge clk);
        bus.load_en   = 1'b0;
        expect_after("old_word", 0, mk(8'h01, 16'h0000, 16'h0000, 1'b0, 1'b0));
        expect_after("new_word_fetch", 1, mk(8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0));
        expect_after("new_word_exec", 1, mk(8'h01, 16'h0005, 16'h0000, 1'b0, 1'b0));

        clear_mem();
        reset = 1'b1;
        for (int i = 0; i < 256; i++)
            expect_after($sformatf("wrap[%0d]", i), 1,
                         mk(8'(i + 1), 16'h0000, 16'h0000, 1'b0, 1'b0));

        clear_mem();
        prog_q = '{16'h0180};
        for (int i = 0; i < 12; i++) prog_q.push_back(16'h1110);
        load_prog();
        reset = 1'b1;
        expect_after("add_first", 2, mk(8'h02, 16'h0100, 16'h0100, 1'b0, 1'b0));
        expect_after("add_8000", 7, mk(8'h09, 16'h8000, 16'h8000, 1'b1, 1'b0));
        expect_after("add_wrap_zero", 1, mk(8'h0A, 16'h0000, 16'h0000, 1'b0, 1'b1));

        clear_mem();
        prog_q = '{16'h6000, 16'h8020};
        load_prog();
        reset = 1'b1;
        expect_after("cmp_r0r0", 1, mk(8'h01, 16'h0000, 16'h0000, 1'b0, 1'b1));
`ifdef COND_BRANCH_EN
        expect_after("jz_taken", 1, mk(8'h20, 16'h0000, 16'h0000, 1'b0, 1'b1));
`else
        expect_after("op8_nop", 1, mk(8'h02, 16'h0000, 16'h0000, 1'b0, 1'b1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
